// File: rtl/tdc_frame_tx_if.sv
// Byte-stream valid/ready link from the TDC framer to the UART transmitter.
interface tdc_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/tdc_frame_tx.sv
// Converts one thermometer snapshot into a tap count (two-stage popcount) and
// ships it as a 5-byte checksummed frame over a valid/ready byte stream.
module tdc_frame_tx #(
    parameter int unsigned LENGTH    = 128,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk10m,
    input  logic              rst,
    input  logic [LENGTH-1:0] therm,
    input  logic              therm_valid,
    tdc_frame_tx_if.master    tx,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned NumChunks = LENGTH / 16;

    typedef enum logic [1:0] {StIdle, StCalc, StSend} state_e;

    state_e          state_q, state_d;
    logic [1:0]      calc_cnt_q, calc_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      seq_q, seq_d;
    logic [7:0]      drop_q, drop_d;
    logic [4:0][7:0] frame_q, frame_d;
    logic [4:0]      part_q [NumChunks];
    logic [4:0]      part_d [NumChunks];
    logic [15:0]     count_q, count_d;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            accept;
    logic            s2_en;

    assign accept = (state_q == StIdle) && therm_valid;
    assign s2_en  = (state_q == StCalc) && (calc_cnt_q == 2'd0);

    // Plain popcount: bubbles count as ones, no edge detection.
    always_comb begin
        for (int c = 0; c < NumChunks; c++) begin
            part_d[c] = '0;
            for (int b = 0; b < 16; b++) begin
                part_d[c] = part_d[c] + {4'd0, therm[c*16+b]};
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int c = 0; c < NumChunks; c++) begin
            count_d = count_d + {11'd0, part_q[c]};
        end
    end

    always_comb begin
        state_d    = state_q;
        calc_cnt_d = calc_cnt_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        frame_d    = frame_q;
        drop_d     = drop_q;
        frame_done = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;

        if (therm_valid && (state_q != StIdle) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StCalc;
                    calc_cnt_d = 2'd0;
                end
            end
            StCalc: begin
                calc_cnt_d = calc_cnt_q + 2'd1;
                if (calc_cnt_q == 2'd2) begin
                    frame_d[0] = SYNC_BYTE;
                    frame_d[1] = seq_q;
                    frame_d[2] = count_q[15:8];
                    frame_d[3] = count_q[7:0];
                    frame_d[4] = seq_q ^ count_q[15:8] ^ count_q[7:0];
                    idx_d      = 3'd0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                tx_valid = 1'b1;
                tx_data  = frame_q[idx_q];
                if (tx.tx_ready) begin
                    if (idx_q == 3'd4) begin
                        frame_done = 1'b1;
                        seq_d      = seq_q + 8'd1;
                        state_d    = StIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk10m) begin
        if (rst) begin
            state_q    <= StIdle;
            calc_cnt_q <= '0;
            idx_q      <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            frame_q    <= '0;
            count_q    <= '0;
            for (int c = 0; c < NumChunks; c++) begin
                part_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            calc_cnt_q <= calc_cnt_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            frame_q    <= frame_d;
            if (accept) begin
                for (int c = 0; c < NumChunks; c++) begin
                    part_q[c] <= part_d[c];
                end
            end
            if (s2_en) begin
                count_q <= count_d;
            end
        end
    end

    assign tx.tx_data  = tx_data;
    assign tx.tx_valid = tx_valid;
    assign busy        = (state_q != StIdle);
    assign drop_cnt    = drop_q;

endmodule
